aes_inv_key_schedule: RTL and testbench
=======================================

// Module: aes_inv_key_schedule
// PURPOSE
//  Inverse AES-128 key schedule, the reverse of KeyExpansion. Takes the final round key (round 10)
//  and iteratively regenerates round keys 10 down to 0, one per handshake, for the decryption datapath.
//  Round 0 equals the original cipher key. Sits between key storage and the inverse-cipher rounds.
//  Replaces the 1408-bit full schedule with a 128-bit state register.
// PARAMETERS
//  NUM_ROUNDS  10  round count; only 10 (AES-128) is supported
//  SUB_PIPE    0   1 = register the SubWord result; this inserts a one-cycle bubble between keys
// PORTS
//  clk         in   1    system clock, rising edge
//  n_rst       in   1    asynchronous active-low reset
//  start       in   1    load last_key and begin; sampled only in IDLE
//  last_key    in   128  round-10 key; bits [127:96] = w40 (first word), byte [127:120] first
//  abort       in   1    synchronous return to IDLE; no done pulse
//  rkey_ready  in   1    consumer accepts rkey this cycle
//  rkey        out  128  current round key, same word/byte ordering as last_key
//  rkey_idx    out  4    round index of rkey (10..0)
//  rkey_valid  out  1    rkey/rkey_idx valid
//  busy        out  1    high in any state other than IDLE
//  done        out  1    one-cycle pulse after round key 0 is accepted
// BEHAVIOUR
//  Reset values: rkey=0, rkey_idx=0, rkey_valid=0, busy=0, done=0, state=IDLE.
//  States: IDLE, EMIT, CALC (CALC is used only when SUB_PIPE=1).
//  IDLE: on start=1, rkey<=last_key, rkey_idx<=NUM_ROUNDS, go to EMIT.
//    rkey_valid rises the cycle after start.
//  EMIT: rkey_valid=1. rkey and rkey_idx are held stable until rkey_valid&&rkey_ready.
//    On handshake with rkey_idx==0: go to IDLE, done=1 for one cycle, rkey_valid=0.
//    On handshake with rkey_idx>0 and SUB_PIPE=0: rkey<=prev(rkey), idx--, stay in EMIT.
//      This gives back-to-back keys. All 11 keys are delivered in 11 cycles when ready is held high.
//    On handshake with rkey_idx>0 and SUB_PIPE=1: latch SubWord, go to CALC with rkey_valid=0.
//  CALC: rkey<=prev(rkey), idx--, go to EMIT.
//  prev() for round r=rkey_idx, with input words w0..w3 and output words p0..p3:
//    p3=w3^w2; p2=w2^w1; p1=w1^w0; p0=w0^SubWord(RotWord(p3))^{Rcon[r],24'h0}.
//    Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. RotWord(a,b,c,d)=(b,c,d,a).
//  S-box: forward AES S-box, four combinational lookups from a local 256-entry function.
//    The forward S-box is required here, not the inverse S-box.
//  start during busy: ignored; the current sequence is unaffected.
//  abort: highest priority in any state. Next cycle: IDLE, rkey_valid=0, done=0, rkey retains its value.
//    abort and start together in IDLE: abort wins and start is dropped.
//  n_rst asserted mid-sequence: immediate return to reset values.
//  rkey_idx never wraps below 0. No 0 -> 15 transition is permitted.
//  done and rkey_valid are never high in the same cycle.
// TESTING
//  1. FIPS-197 A.1: start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, ready=1
//     -> idx 10..0 on consecutive cycles.
//     idx9=ac7766f319fadc2128d12941575c006e, idx1=a0fafe1788542cb123a339392a6c7605,
//     idx0=2b7e151628aed2a6abf7158809cf4f3c; done the following cycle.
//  2. Backpressure: ready toggles pseudo-randomly -> rkey/idx stable while valid&&!ready.
//     Same 11 keys in order; exactly 11 handshakes and one done.
//  3. Round trip: random keys through KeyExpansion; feed schedule[1280:1407] as last_key
//     -> each emitted key matches the schedule slice for its idx (key k = bits [128k:128k+127]).
//  4. start pulsed at idx=5 -> ignored, sequence continues.
//     Then abort at idx=3 -> IDLE next cycle, no done; a new start runs cleanly from idx 10.
//  5. n_rst low for 1 cycle at idx=7 -> all outputs 0 immediately; restart yields correct sequence.
//  6. SUB_PIPE=1 with ready=1 -> one valid-low bubble between keys, 21 cycles start-to-done, same keys as test 1.

Source files
------------

// File: rtl/aes_inv_key_schedule.sv
// Inverse AES-128 key schedule: starts from the round-10 key and walks back to the cipher key,
// emitting one round key per valid/ready handshake.
module aes_inv_key_schedule #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter bit          SUB_PIPE   = 1'b0
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         abort,
    input  logic         rkey_ready,
    output logic [127:0] rkey,
    output logic [3:0]   rkey_idx,
    output logic         rkey_valid,
    output logic         busy,
    output logic         done
);

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 4;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EMIT, CALC} state_t;

    state_t              state;
    state_t              state_next;
    logic [WORD_W-1:0]   sub_q;
    logic [WORD_W-1:0]   sub_d;
    logic [KEY_W-1:0]    rkey_d;
    logic [IDX_W-1:0]    idx_d;
    logic                done_d;
    logic                valid_d;
    logic                busy_d;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] pos;
        pos = 11'(2047) - {b, 3'b000};
        return SBOX_TABLE[pos -: 8];
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [IDX_W-1:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // One backward step of KeyExpansion from the current round key.
    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] p0, p1, p2, p3;
    logic [WORD_W-1:0] sub_c;
    logic [WORD_W-1:0] sub_sel;
    logic [KEY_W-1:0]  prev_key;
    logic              hs;

    always_comb begin
        w0       = rkey[127:96];
        w1       = rkey[95:64];
        w2       = rkey[63:32];
        w3       = rkey[31:0];
        p3       = w3 ^ w2;
        p2       = w2 ^ w1;
        p1       = w1 ^ w0;
        sub_c    = sub_word({p3[23:0], p3[31:24]});
        sub_sel  = SUB_PIPE ? sub_q : sub_c;
        p0       = w0 ^ sub_sel ^ {rcon(rkey_idx), 24'h0};
        prev_key = {p0, p1, p2, p3};
        hs       = rkey_valid && rkey_ready;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_next = EMIT;
                EMIT: begin
                    if (hs) begin
                        if (rkey_idx == '0) state_next = IDLE;
                        else if (SUB_PIPE)  state_next = CALC;
                        else                state_next = EMIT;
                    end
                end
                CALC:    state_next = EMIT;
                default: state_next = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and datapath; abort leaves rkey untouched.
    always_comb begin
        rkey_d  = rkey;
        idx_d   = rkey_idx;
        sub_d   = sub_q;
        done_d  = 1'b0;
        valid_d = (state_next == EMIT);
        busy_d  = (state_next != IDLE);
        if (!abort) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rkey_d = last_key;
                        idx_d  = IDX_W'(NUM_ROUNDS);
                    end
                end
                EMIT: begin
                    if (hs && rkey_idx == '0) begin
                        done_d = 1'b1;
                    end else if (hs) begin
                        if (SUB_PIPE) begin
                            sub_d = sub_c;
                        end else begin
                            rkey_d = prev_key;
                            idx_d  = rkey_idx - IDX_W'(1);
                        end
                    end
                end
                CALC: begin
                    if (rkey_idx != '0) begin
                        rkey_d = prev_key;
                        idx_d  = rkey_idx - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rkey       <= '0;
            rkey_idx   <= '0;
            rkey_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sub_q      <= '0;
        end else begin
            rkey       <= rkey_d;
            rkey_idx   <= idx_d;
            rkey_valid <= valid_d;
            busy       <= busy_d;
            done       <= done_d;
            sub_q      <= sub_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: forward KeyExpansion model (S-box derived from GF(2^8) inversion)
// predicts every round key; one negedge process checks both design variants.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic         abort;
    logic         ready;
    logic [127:0] last_key;
    logic         sel;
    logic         start0, start1;
    logic [127:0] r0, r1;
    logic [3:0]   i0, i1;
    logic         v0, v1, b0, b1, d0, d1;
    logic [127:0] m_rkey;
    logic [3:0]   m_idx;
    logic         m_valid, m_busy, m_done;

    always #5 clk = ~clk;

    assign start0  = start && !sel;
    assign start1  = start && sel;
    assign m_rkey  = sel ? r1 : r0;
    assign m_idx   = sel ? i1 : i0;
    assign m_valid = sel ? v1 : v0;
    assign m_busy  = sel ? b1 : b0;
    assign m_done  = sel ? d1 : d0;

    aes_inv_key_schedule #(.NUM_ROUNDS(10), .SUB_PIPE(1'b0)) dut0 (
        .clk(clk), .n_rst(n_rst), .start(start0), .last_key(last_key), .abort(abort),
        .rkey_ready(ready), .rkey(r0), .rkey_idx(i0), .rkey_valid(v0), .busy(b0), .done(d0));

    aes_inv_key_schedule #(.NUM_ROUNDS(10), .SUB_PIPE(1'b1)) dut1 (
        .clk(clk), .n_rst(n_rst), .start(start1), .last_key(last_key), .abort(abort),
        .rkey_ready(ready), .rkey(r1), .rkey_idx(i1), .rkey_valid(v1), .busy(b1), .done(d1));

    int           tests = 0;
    int           fails = 0;
    logic [7:0]   sb [0:255];
    logic [127:0] exp_keys [0:10];
    logic [127:0] got_keys [0:10];
    int           exp_idx;
    bit           done_due, chk_en, seen_first, prev_stall;
    int           hs_cnt, done_cnt, cyc, t_first, t_done, bubbles;
    logic [127:0] prev_rkey;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward AES-128 KeyExpansion into exp_keys[0..10].
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic arm();
        exp_idx = 10; hs_cnt = 0; done_cnt = 0; seen_first = 0; bubbles = 0;
        done_due = 0; t_first = 0; t_done = 0; prev_stall = 0; chk_en = 1;
        for (int r = 0; r <= 10; r++) got_keys[r] = '0;
    endtask

    // Scoreboard: key per index, hold under backpressure, handshake ordering, done pulse.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (n_rst && chk_en) begin
            check("valid_done_excl", 128'(m_valid && m_done), 128'(0));
            check("done", 128'(m_done), 128'(done_due));
            if (m_done) begin done_cnt++; t_done = cyc; end
            done_due = 0;
            if (m_valid) begin
                if (!seen_first) begin seen_first = 1; t_first = cyc; end
                check("idx", 128'(m_idx), 128'(exp_idx));
                if (m_idx <= 4'd10) begin
                    check("key", m_rkey, exp_keys[m_idx]);
                    got_keys[m_idx] = m_rkey;
                end
                if (prev_stall) check("hold_key", m_rkey, prev_rkey);
                if (ready) begin
                    hs_cnt++;
                    if (exp_idx == 0) done_due = 1;
                    else exp_idx--;
                end
            end else if (seen_first && done_cnt == 0 && !done_due) begin
                bubbles++;
            end
            prev_stall = m_valid && !ready;
            prev_rkey  = m_rkey;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input logic [3:0] target);
        bit ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (m_valid && m_idx == target) ok = 1;
            else step();
        end
        check($sformatf("reach_idx%0d", target), 128'(ok), 128'(1));
    endtask

    // mode 0: ready held high; mode 1: random ready. exp_cyc < 0 skips the timing checks.
    task automatic run_seq(input logic [127:0] ck, input bit pipe, input int mode, input int exp_cyc);
        bit got_done = 0;
        expand(ck);
        sel = pipe;
        arm();
        last_key = exp_keys[10];
        start = 1;
        ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        for (int n = 0; n < 300 && !got_done; n++) begin
            step();
            start = 0;
            if (mode != 0) ready = 1'($urandom_range(0, 1));
            if (m_done) got_done = 1;
        end
        @(negedge clk);
        #1;
        check("done_seen", 128'(got_done), 128'(1));
        check("handshakes", 128'(hs_cnt), 128'(11));
        check("done_count", 128'(done_cnt), 128'(1));
        if (exp_cyc >= 0) begin
            check("start_to_done", 128'(t_done - t_first), 128'(exp_cyc));
            check("bubbles", 128'(bubbles), pipe ? 128'(10) : 128'(0));
        end
        check("busy_after", 128'(m_busy), 128'(0));
        ready = 1;
        step();
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        n_rst = 0; start = 0; abort = 0; ready = 0; last_key = '0; sel = 0;
        chk_en = 0; cyc = 0;
        build_sbox();
        check("model_sbox00", 128'(sb[8'h00]), 128'h63);
        check("model_sbox53", 128'(sb[8'h53]), 128'hed);
        expand(FIPS_KEY);
        check("model_rk10", exp_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_rk1", exp_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);

        #12;
        check("rst_rkey0", r0, 128'h0);
        check("rst_idx0", 128'(i0), 128'h0);
        check("rst_flags0", 128'({v0, b0, d0}), 128'h0);
        check("rst_flags1", 128'({r1 != 0, i1 != 0, v1, b1, d1}), 128'h0);
        step();
        n_rst = 1;
        step();

        // FIPS-197 A.1 back-to-back, plus pinned literals.
        run_seq(FIPS_KEY, 0, 0, 11);
        check("lit_idx9", got_keys[9], 128'hac7766f319fadc2128d12941575c006e);
        check("lit_idx1", got_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("lit_idx0", got_keys[0], FIPS_KEY);

        // Backpressure and random round trips.
        run_seq(FIPS_KEY, 0, 1, -1);
        for (int t = 0; t < 4; t++)
            run_seq({$urandom(), $urandom(), $urandom(), $urandom()}, 0, t % 2, (t % 2) ? -1 : 11);

        // start+abort together in IDLE: abort wins.
        sel = 0; start = 1; abort = 1; last_key = 128'h1;
        step();
        start = 0; abort = 0;
        check("abort_start_idle", 128'({m_valid, m_busy, m_done}), 128'h0);

        // start mid-sequence ignored, then abort at idx 3.
        expand({$urandom(), $urandom(), $urandom(), $urandom()});
        sel = 0; arm(); last_key = exp_keys[10]; start = 1; ready = 1;
        step();
        start = 0;
        wait_idx(4'd5);
        start = 1; last_key = {$urandom(), $urandom(), $urandom(), $urandom()};
        step();
        start = 0;
        wait_idx(4'd3);
        ready = 0; abort = 1;
        step();
        abort = 0;
        check("abort_flags", 128'({m_valid, m_busy, m_done}), 128'h0);
        check("abort_rkey_kept", m_rkey, exp_keys[3]);
        step();
        check("abort_no_done", 128'(m_done), 128'h0);
        ready = 1;
        run_seq({$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0, 11);

        // Reset pulse at idx 7.
        expand({$urandom(), $urandom(), $urandom(), $urandom()});
        sel = 0; arm(); last_key = exp_keys[10]; start = 1; ready = 1;
        step();
        start = 0;
        wait_idx(4'd7);
        n_rst = 0;
        #1;
        check("midrst_rkey", m_rkey, 128'h0);
        check("midrst_flags", 128'({m_idx, m_valid, m_busy, m_done}), 128'h0);
        step();
        n_rst = 1;
        step();
        run_seq({$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0, 11);

        // Registered SubWord variant.
        run_seq(FIPS_KEY, 1, 0, 21);
        check("pipe_idx9", got_keys[9], 128'hac7766f319fadc2128d12941575c006e);
        check("pipe_idx0", got_keys[0], FIPS_KEY);
        run_seq({$urandom(), $urandom(), $urandom(), $urandom()}, 1, 1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
